imm_ext_sequencer: RTL and testbench
====================================

Name: imm_ext_sequencer

Overview:
- Pipelined immediate-extension controller for the 32-bit MIPS-subset datapath.
- Accepts an instruction word over a valid/ready handshake and decodes the opcode.
- Selects zero, sign or upper (lui) extension of the 16-bit immediate and presents one registered 32-bit operand to the ALU-B mux over a second valid/ready handshake.
- Keeps saturating usage counters for the zero- and sign-extension paths.

Parameters:
- CNT_W, 16, width of each saturating usage counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  instruction word valid
- in_ready  output  1  block can accept an instruction this cycle
- instr  input  32  instruction word; opcode = instr[31:26], immediate = instr[15:0]
- out_valid  output  1  registered result valid
- out_ready  input  1  consumer accepts the result this cycle
- imm_out  output  32  extended immediate
- ext_mode  output  2  00 NONE, 01 ZERO, 10 SIGN, 11 UPPER
- illegal  output  1  opcode not recognised (qualified by out_valid)
- zext_cnt  output  CNT_W  count of ZERO results accepted downstream
- sext_cnt  output  CNT_W  count of SIGN results accepted downstream

Behaviour:
- Reset: asynchronous, active-high. While reset is high and on release, all outputs except in_ready are 0, FSM is EMPTY, counters are 0.
- FSM states: EMPTY and FULL.
  - EMPTY: in_ready = 1, out_valid = 0.
  - FULL: out_valid = 1, in_ready = out_ready (combinational pass-through).
- Transitions:
  - EMPTY & in_valid: capture the decoded result, go to FULL.
  - FULL & out_ready & in_valid: capture the new result, stay FULL. This gives back-to-back throughput of 1 per cycle.
  - FULL & out_ready & !in_valid: go to EMPTY.
  - FULL & !out_ready: hold all outputs stable. Input is not accepted.
- Latency: exactly 1 cycle from the accept edge (in_valid & in_ready) to out_valid.
- Decode (opcode hex):
  - 0C, 0D, 0E (andi, ori, xori): ZERO. imm_out = {16'h0, imm}.
  - 08, 09, 0A, 0B, 23, 2B, 04, 05: SIGN. imm_out = {{16{imm[15]}}, imm}.
  - 0F (lui): UPPER. imm_out = {imm, 16'h0}.
  - 00 (R-type) and 02, 03 (jumps): NONE. imm_out = 0, illegal = 0.
  - Any other opcode: NONE, imm_out = 0, illegal = 1.
- Counters:
  - Increment on the output handshake (out_valid & out_ready), never on capture.
  - zext_cnt increments when ext_mode = ZERO; sext_cnt when ext_mode = SIGN.
  - Both saturate at all-ones and do not wrap.
- Reset asserted mid-operation drops any held result and clears the counters immediately, with no clock edge required.
- in_valid while in_ready = 0 is ignored. The producer must hold instr until accepted.
- Capturing a new result in the same cycle the held one is consumed counts the consumed one only.

Optional Feature:
- Macro: IMM_BRANCH_SHIFT_EN.
- Defined: for opcodes 04 and 05, imm_out = {{14{imm[15]}}, imm, 2'b00}, a word-to-byte branch offset. ext_mode = SIGN and the result counts in sext_cnt.
- Undefined: 04 and 05 use plain SIGN extension like other SIGN opcodes.

Test Plan:
- Reset, then ori with imm 16'h8001 and out_ready = 1 -> one cycle later out_valid = 1, imm_out = 32'h0000_8001, ext_mode = 01, zext_cnt = 1 after the handshake.
- addi with imm 16'hFFFE -> imm_out = 32'hFFFF_FFFE, ext_mode = 10, sext_cnt increments by 1.
- lui 16'h1234, then out_ready held 0 for 3 cycles -> imm_out stays 32'h1234_0000, in_ready = 0, counters unchanged. On release, exactly one handshake occurs.
- Opcode 6'h3F -> illegal = 1, imm_out = 0, ext_mode = 00. Opcode 00 -> illegal = 0.
- Streaming 5 consecutive andi with out_ready = 1 -> 5 results on 5 consecutive cycles, zext_cnt = 5. Asserting reset mid-stream -> out_valid = 0 and counters = 0 without a clock edge.
- beq with imm 16'h0003 -> imm_out = 32'h0000_000C with IMM_BRANCH_SHIFT_EN defined, 32'h0000_0003 without it.
- With CNT_W = 2, issue 5 SIGN results -> sext_cnt saturates at 3.

Source files
------------

// File: rtl/imm_ext_sequencer.sv
// Decodes an instruction opcode and zero/sign/upper-extends its 16-bit immediate for the ALU-B operand.
// Latency: 1 cycle from input accept to out_valid; back-to-back throughput of one result per cycle.
// Backpressure: a held result stays stable while out_ready is low; in_ready follows out_ready when full.
// Optional: define IMM_BRANCH_SHIFT_EN to scale beq/bne offsets (opcodes 04/05) to byte offsets.
module imm_ext_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      imm_out,
    output logic [1:0]       ext_mode,
    output logic             illegal,
    output logic [CNT_W-1:0] zext_cnt,
    output logic [CNT_W-1:0] sext_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] imm;
        logic [1:0]  mode;
        logic        ill;
    } res_t;

    localparam logic [1:0] MODE_NONE  = 2'b00;
    localparam logic [1:0] MODE_ZERO  = 2'b01;
    localparam logic [1:0] MODE_SIGN  = 2'b10;
    localparam logic [1:0] MODE_UPPER = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t     state;
    state_t     state_nx;
    res_t       res_q;
    res_t       res_d;
    logic       load;
    logic       fire;
    logic [5:0] opcode;
    logic [15:0] imm;

    assign opcode = instr[31:26];
    assign imm    = instr[15:0];

    // Opcode decode and immediate extension for the word currently on instr.
    always_comb begin
        res_d = '0;
        case (opcode)
            6'h0C, 6'h0D, 6'h0E: begin
                res_d.mode = MODE_ZERO;
                res_d.imm  = {16'h0000, imm};
            end
`ifdef IMM_BRANCH_SHIFT_EN
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B: begin
                res_d.mode = MODE_SIGN;
                res_d.imm  = {{16{imm[15]}}, imm};
            end
            // Branch offsets are word counts; present them as byte offsets.
            6'h04, 6'h05: begin
                res_d.mode = MODE_SIGN;
                res_d.imm  = {{14{imm[15]}}, imm, 2'b00};
            end
`else
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B, 6'h04, 6'h05: begin
                res_d.mode = MODE_SIGN;
                res_d.imm  = {{16{imm[15]}}, imm};
            end
`endif
            6'h0F: begin
                res_d.mode = MODE_UPPER;
                res_d.imm  = {imm, 16'h0000};
            end
            6'h00, 6'h02, 6'h03: begin
                res_d.mode = MODE_NONE;
            end
            default: begin
                res_d.mode = MODE_NONE;
                res_d.ill  = 1'b1;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    // Next state, handshake outputs and result-capture enable.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        load      = 1'b0;
        case (state)
            EMPTY: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load     = 1'b1;
                    state_nx = FULL;
                end
            end
            FULL: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        load = 1'b1;
                    end else begin
                        state_nx = EMPTY;
                    end
                end
            end
            default: begin
                state_nx = EMPTY;
            end
        endcase
    end

    assign fire = out_valid & out_ready;

    // Result register: only written on an accepted input, so it holds under backpressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_q <= '0;
        end else if (load) begin
            res_q <= res_d;
        end
    end

    // Usage counters advance when a result leaves, counting the departing result only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zext_cnt <= '0;
            sext_cnt <= '0;
        end else if (fire) begin
            if (res_q.mode == MODE_ZERO && zext_cnt != CNT_MAX) begin
                zext_cnt <= zext_cnt + CNT_ONE;
            end
            if (res_q.mode == MODE_SIGN && sext_cnt != CNT_MAX) begin
                sext_cnt <= sext_cnt + CNT_ONE;
            end
        end
    end

    assign imm_out  = res_q.imm;
    assign ext_mode = res_q.mode;
    assign illegal  = res_q.ill;

endmodule

// File: tb/tb_imm_ext_sequencer.sv
// Bench for imm_ext_sequencer: directed instruction stream, reference model, per-cycle compare.
// Latency: n/a (checks one-cycle latency of the DUT).
// Backpressure: exercises out_ready stalls and back-to-back streaming.
module tb_imm_ext_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] imm_out;
    logic [1:0]  ext_mode;
    logic        illegal;
    logic [15:0] zext_cnt;
    logic [15:0] sext_cnt;

    // Narrow-counter instance sharing the same stimulus, used for saturation.
    logic        in_ready2;
    logic        out_valid2;
    logic [31:0] imm_out2;
    logic [1:0]  ext_mode2;
    logic        illegal2;
    logic [1:0]  zext_cnt2;
    logic [1:0]  sext_cnt2;

    int n_cmp = 0;
    int n_bad = 0;

    imm_ext_sequencer #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .out_valid(out_valid), .out_ready(out_ready),
        .imm_out(imm_out), .ext_mode(ext_mode), .illegal(illegal),
        .zext_cnt(zext_cnt), .sext_cnt(sext_cnt)
    );

    imm_ext_sequencer #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .instr(instr), .out_valid(out_valid2), .out_ready(out_ready),
        .imm_out(imm_out2), .ext_mode(ext_mode2), .illegal(illegal2),
        .zext_cnt(zext_cnt2), .sext_cnt(sext_cnt2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void ref_decode(input logic [31:0] w, output logic [31:0] r_imm,
                                       output logic [1:0] r_mode, output logic r_ill);
        logic [5:0]  op;
        logic [15:0] im;
        op = w[31:26];
        im = w[15:0];
        r_imm = 32'h0;
        r_mode = 2'd0;
        r_ill = 1'b0;
        if (op == 6'h0C || op == 6'h0D || op == 6'h0E) begin
            r_mode = 2'd1;
            r_imm = {16'h0, im};
        end else if (op == 6'h04 || op == 6'h05) begin
            r_mode = 2'd2;
`ifdef IMM_BRANCH_SHIFT_EN
            r_imm = 32'($signed(im)) * 4;
`else
            r_imm = 32'($signed(im));
`endif
        end else if (op == 6'h08 || op == 6'h09 || op == 6'h0A || op == 6'h0B ||
                     op == 6'h23 || op == 6'h2B) begin
            r_mode = 2'd2;
            r_imm = 32'($signed(im));
        end else if (op == 6'h0F) begin
            r_mode = 2'd3;
            r_imm = {im, 16'h0};
        end else if (op != 6'h00 && op != 6'h02 && op != 6'h03) begin
            r_ill = 1'b1;
        end
    endfunction

    logic        m_full;
    logic [31:0] m_imm;
    logic [1:0]  m_mode;
    logic        m_ill;
    int          m_z, m_s, m_s2;

    // Model: one result slot, counts results as they leave, narrow counter caps at 3.
    always @(posedge clk or posedge reset) begin
        logic [31:0] t_imm;
        logic [1:0]  t_mode;
        logic        t_ill;
        if (reset) begin
            m_full <= 1'b0; m_imm <= 0; m_mode <= 0; m_ill <= 0;
            m_z <= 0; m_s <= 0; m_s2 <= 0;
        end else begin
            if (m_full && out_ready) begin
                if (m_mode == 2'd1) m_z <= (m_z < 65535) ? m_z + 1 : m_z;
                if (m_mode == 2'd2) begin
                    m_s  <= (m_s < 65535) ? m_s + 1 : m_s;
                    m_s2 <= (m_s2 < 3) ? m_s2 + 1 : m_s2;
                end
            end
            if (in_valid && (!m_full || out_ready)) begin
                ref_decode(instr, t_imm, t_mode, t_ill);
                m_imm <= t_imm; m_mode <= t_mode; m_ill <= t_ill;
                m_full <= 1'b1;
            end else if (m_full && out_ready) begin
                m_full <= 1'b0;
            end
        end
    end

    // Compare on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("out_valid", 32'(out_valid), 32'(m_full));
            chk("in_ready", 32'(in_ready), 32'(!m_full || out_ready));
            if (out_valid) begin
                chk("imm_out", imm_out, m_imm);
                chk("ext_mode", 32'(ext_mode), 32'(m_mode));
                chk("illegal", 32'(illegal), 32'(m_ill));
            end
            chk("zext_cnt", 32'(zext_cnt), m_z);
            chk("sext_cnt", 32'(sext_cnt), m_s);
            chk("sext_cnt_w2", 32'(sext_cnt2), m_s2);
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [31:0] mk(input logic [5:0] op, input logic [15:0] im);
        return {op, 10'h000, im};
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one instruction until accepted; returns 1 ns after the accept edge.
    task automatic issue(input logic [31:0] w, input logic ordy);
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1;
        instr = w;
        out_ready = ordy;
        for (int k = 0; k < 20 && !acc; k++) begin
            #1;
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_timeout at %0t: got no accept, expected accept within 20 cycles", $time);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; instr = 32'h0;
        cyc(2);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_imm_out", imm_out, 32'h0);
        chk("rst_zext", 32'(zext_cnt), 32'd0);
        chk("rst_sext", 32'(sext_cnt), 32'd0);
        reset = 1'b0;
        cyc(1);

        // ori 8001: zero extension
        issue(mk(6'h0D, 16'h8001), 1'b1);
        chk("ori_valid", 32'(out_valid), 32'd1);
        chk("ori_imm", imm_out, 32'h0000_8001);
        chk("ori_mode", 32'(ext_mode), 32'd1);
        chk("ori_zext_before", 32'(zext_cnt), 32'd0);
        cyc(1);
        chk("ori_zext_after", 32'(zext_cnt), 32'd1);
        chk("ori_drained", 32'(out_valid), 32'd0);

        // addi FFFE: sign extension
        issue(mk(6'h08, 16'hFFFE), 1'b1);
        chk("addi_imm", imm_out, 32'hFFFF_FFFE);
        chk("addi_mode", 32'(ext_mode), 32'd2);
        cyc(1);
        chk("addi_sext", 32'(sext_cnt), 32'd1);

        // lui 1234 with a 3-cycle stall
        issue(mk(6'h0F, 16'h1234), 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("lui_hold_imm", imm_out, 32'h1234_0000);
            chk("lui_hold_rdy", 32'(in_ready), 32'd0);
            chk("lui_hold_mode", 32'(ext_mode), 32'd3);
            cyc(1);
        end
        out_ready = 1'b1;
        cyc(1);
        chk("lui_one_hs", 32'(out_valid), 32'd0);
        chk("lui_zext", 32'(zext_cnt), 32'd1);
        chk("lui_sext", 32'(sext_cnt), 32'd1);

        // illegal opcode then R-type, back to back
        issue(mk(6'h3F, 16'h5555), 1'b1);
        chk("ill_flag", 32'(illegal), 32'd1);
        chk("ill_imm", imm_out, 32'h0);
        chk("ill_mode", 32'(ext_mode), 32'd0);
        issue(mk(6'h00, 16'h5555), 1'b1);
        chk("rtype_flag", 32'(illegal), 32'd0);
        cyc(1);

        // stream of 5 andi
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            instr = mk(6'h0C, 16'(i + 1));
            cyc(1);
            chk("stream_valid", 32'(out_valid), 32'd1);
            chk("stream_imm", imm_out, 32'(i + 1));
        end
        in_valid = 1'b0;
        cyc(1);
        chk("stream_zext", 32'(zext_cnt), 32'd6);

        // asynchronous reset in the middle of a stream
        in_valid = 1'b1;
        instr = mk(6'h0C, 16'h00AA);
        cyc(2);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_zext", 32'(zext_cnt), 32'd0);
        chk("arst_sext", 32'(sext_cnt), 32'd0);
        chk("arst_imm", imm_out, 32'h0);
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b0;
        cyc(1);

        // beq offset 3
        issue(mk(6'h04, 16'h0003), 1'b1);
`ifdef IMM_BRANCH_SHIFT_EN
        chk("beq_imm", imm_out, 32'h0000_000C);
`else
        chk("beq_imm", imm_out, 32'h0000_0003);
`endif
        chk("beq_mode", 32'(ext_mode), 32'd2);
        cyc(1);
        chk("beq_sext", 32'(sext_cnt), 32'd1);

        // four more SIGN results: narrow counter saturates at 3
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            instr = mk(6'h23, 16'(16'h8000 + i));
            cyc(1);
        end
        in_valid = 1'b0;
        cyc(2);
        chk("sat_sext16", 32'(sext_cnt), 32'd5);
        chk("sat_sext2", 32'(sext_cnt2), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
